// File: rtl/memoria_pkg.sv
// Shared types and constants for the parametrised data memory.
package memoria_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    RESPOSTA
  } estado_t;

  typedef enum logic {
    OP_LER,
    OP_ESCREVER
  } op_t;

  localparam int LARGURA_PADRAO      = 32;
  localparam int PROFUNDIDADE_PADRAO = 2048;

  // Wait counter only has to hold LATENCIA-2; keep at least one bit.
  function automatic int largura_contador(input int latencia);
    return (latencia > 2) ? $clog2(latencia - 1) : 1;
  endfunction

endpackage

// File: rtl/memoria_array.sv
// Single-port storage: byte-lane synchronous write, registered read, word i preloaded with i.
module memoria_array
  import memoria_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LARGURA_END  = $clog2(PROFUNDIDADE)
) (
  input  logic                     clock,
  input  logic                     escrever,
  input  logic                     ler,
  input  logic [LARGURA_END-1:0]   endereco,
  input  logic [LARGURA-1:0]       dado_escrita,
  input  logic [LARGURA/8-1:0]     byte_en,
  output logic [LARGURA-1:0]       dado_lido
);

  localparam int N_BYTES = LARGURA / 8;

  typedef logic [LARGURA-1:0] palavra_t;
  typedef palavra_t mem_t [PROFUNDIDADE];

  function automatic mem_t carga_inicial();
    mem_t m;
    for (int i = 0; i < PROFUNDIDADE; i++) begin
      m[i] = LARGURA'(i);
    end
    return m;
  endfunction

  mem_t mem_q = carga_inicial();

  logic [LARGURA-1:0] dado_lido_q, dado_lido_d;

  always_comb begin
    dado_lido_d = dado_lido_q;
    if (ler) begin
      dado_lido_d = mem_q[endereco];
    end
  end

  always_ff @(posedge clock) begin
    dado_lido_q <= dado_lido_d;
    for (int k = 0; k < N_BYTES; k++) begin
      if (escrever && byte_en[k]) begin
        mem_q[endereco][8*k +: 8] <= dado_escrita[8*k +: 8];
      end
    end
  end

  assign dado_lido = dado_lido_q;

endmodule

// File: rtl/memoria_dados_param.sv
// MEM-stage data memory with latency handshake and range check.
// Optional byte-lane writes are enabled by defining MEM_BYTE_WRITE_EN.
//
// state    | meaning
// OCIOSO   | idle, a request can be accepted
// ESPERA   | request latched, counting down the remaining latency
// RESPOSTA | access committed, memPronto high, new request may be accepted
module memoria_dados_param
  import memoria_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int LATENCIA     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          memEndereco,
  input  logic [LARGURA-1:0]   memValor,
  input  logic [LARGURA/8-1:0] memByteEn,
  input  logic                 escreverMemoria,
  input  logic                 lerMemoria,
  output logic [LARGURA-1:0]   saida,
  output logic                 memPronto,
  output logic                 memOcupado,
  output logic                 memErro
);

  localparam int N_BYTES     = LARGURA / 8;
  localparam int LARGURA_END = $clog2(PROFUNDIDADE);
  localparam int CW          = largura_contador(LATENCIA);
  localparam int CNT_CARGA   = (LATENCIA > 1) ? LATENCIA - 2 : 0;

  estado_t            estado_q, estado_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  op_t                op_q, op_d;
  logic [31:0]        end_q, end_d;
  logic [LARGURA-1:0] valor_q, valor_d;
  logic               erro_q, erro_d;
  logic               saida_sel_q, saida_sel_d;

  logic               requisicao;
  logic               aceitar;
  logic               commit;
  op_t                op_entrada;
  op_t                c_op;
  logic [31:0]        c_end;
  logic [LARGURA-1:0] c_valor;
  logic [N_BYTES-1:0] c_be;
  logic               no_intervalo;
  logic               arr_escrever;
  logic               arr_ler;
  logic [LARGURA-1:0] arr_dado;

  assign requisicao = escreverMemoria | lerMemoria;
  assign aceitar    = requisicao && (estado_q != ESPERA);
  assign op_entrada = escreverMemoria ? OP_ESCREVER : OP_LER;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    end_d    = end_q;
    valor_d  = valor_q;
    case (estado_q)
      OCIOSO, RESPOSTA: begin
        if (requisicao) begin
          op_d    = op_entrada;
          end_d   = memEndereco;
          valor_d = memValor;
          if (LATENCIA == 1) begin
            estado_d = RESPOSTA;
          end else begin
            estado_d = ESPERA;
            cnt_d    = CW'(CNT_CARGA);
          end
        end else begin
          estado_d = OCIOSO;
        end
      end
      ESPERA: begin
        if (cnt_q == '0) begin
          estado_d = RESPOSTA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // With LATENCIA=1 the commit happens on the accepting edge, so it must use the live inputs.
  always_comb begin
    commit  = (aceitar && (LATENCIA == 1)) || ((estado_q == ESPERA) && (cnt_q == '0));
    c_op    = aceitar ? op_entrada : op_q;
    c_end   = aceitar ? memEndereco : end_q;
    c_valor = aceitar ? memValor : valor_q;
  end

`ifdef MEM_BYTE_WRITE_EN
  logic [N_BYTES-1:0] be_q, be_d;

  always_comb begin
    be_d = be_q;
    if (aceitar) begin
      be_d = memByteEn;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      be_q <= '0;
    end else begin
      be_q <= be_d;
    end
  end

  assign c_be = aceitar ? memByteEn : be_q;
`else
  logic unused_byte_en;
  assign unused_byte_en = ^memByteEn;
  assign c_be           = '1;
`endif

  always_comb begin
    no_intervalo = c_end < 32'(PROFUNDIDADE);
    arr_escrever = commit && (c_op == OP_ESCREVER) && no_intervalo && !reset;
    arr_ler      = commit && (c_op == OP_LER) && no_intervalo && !reset;
    erro_d       = commit && !no_intervalo;
    saida_sel_d  = saida_sel_q;
    if (commit && (c_op == OP_LER)) begin
      saida_sel_d = no_intervalo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      cnt_q       <= '0;
      op_q        <= OP_LER;
      end_q       <= '0;
      valor_q     <= '0;
      erro_q      <= 1'b0;
      saida_sel_q <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      end_q       <= end_d;
      valor_q     <= valor_d;
      erro_q      <= erro_d;
      saida_sel_q <= saida_sel_d;
    end
  end

  memoria_array #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE),
    .LARGURA_END  (LARGURA_END)
  ) u_array (
    .clock        (clock),
    .escrever     (arr_escrever),
    .ler          (arr_ler),
    .endereco     (c_end[LARGURA_END-1:0]),
    .dado_escrita (c_valor),
    .byte_en      (c_be),
    .dado_lido    (arr_dado)
  );

  // saida is zero after reset or an out-of-range read; the array register holds otherwise.
  assign saida      = saida_sel_q ? arr_dado : '0;
  assign memPronto  = (estado_q == RESPOSTA);
  assign memOcupado = (estado_q == ESPERA);
  assign memErro    = erro_q;

endmodule

// File: tb/tb_memoria_dados_param.sv
// Bench: three instances (LATENCIA 1, 3, 4) on shared stimulus, checked against a timer-based model.
module tb_memoria_dados_param;

  localparam int W  = 32;
  localparam int D  = 2048;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] val;
  logic [3:0]  be;
  logic        esc;
  logic        ler;

  logic [31:0] saida_w  [NI];
  logic        pronto_w [NI];
  logic        ocup_w   [NI];
  logic        erro_w   [NI];

  int lat [NI] = '{1, 3, 4};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    memoria_dados_param #(
      .LARGURA      (W),
      .PROFUNDIDADE (D),
      .LATENCIA     ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) dut (
      .clock           (clk),
      .reset           (reset),
      .memEndereco     (addr),
      .memValor        (val),
      .memByteEn       (be),
      .escreverMemoria (esc),
      .lerMemoria      (ler),
      .saida           (saida_w[g]),
      .memPronto       (pronto_w[g]),
      .memOcupado      (ocup_w[g]),
      .memErro         (erro_w[g])
    );
  end

  always #5 clk = ~clk;

  logic [31:0] m_mem   [NI][D];
  logic [31:0] m_saida [NI];
  bit          m_pronto[NI];
  bit          m_erro  [NI];
  bit          m_inf   [NI];
  int          m_rem   [NI];
  bit          m_wr    [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_val   [NI];
  logic [3:0]  m_be    [NI];

  int n_checks = 0;
  int n_err    = 0;

  task automatic model_commit(input int k);
    int ix;
    m_pronto[k] = 1'b1;
    ix = int'(m_addr[k][10:0]);
    if (m_addr[k] >= 32'(D)) begin
      m_erro[k] = 1'b1;
      if (!m_wr[k]) m_saida[k] = '0;
    end else if (m_wr[k]) begin
`ifdef MEM_BYTE_WRITE_EN
      for (int b = 0; b < 4; b++)
        if (m_be[k][b]) m_mem[k][ix][8*b +: 8] = m_val[k][8*b +: 8];
`else
      m_mem[k][ix] = m_val[k];
`endif
    end else begin
      m_saida[k] = m_mem[k][ix];
    end
  endtask

  // Each accepted request completes LATENCIA edges after acceptance; requests while in flight are dropped.
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        m_inf[k] = 1'b0; m_pronto[k] = 1'b0; m_erro[k] = 1'b0; m_saida[k] = '0;
      end else begin
        m_pronto[k] = 1'b0;
        m_erro[k]   = 1'b0;
        if (m_inf[k]) begin
          m_rem[k]--;
          if (m_rem[k] == 0) begin
            m_inf[k] = 1'b0;
            model_commit(k);
          end
        end else if (esc || ler) begin
          m_wr[k]   = esc;
          m_addr[k] = addr;
          m_val[k]  = val;
          m_be[k]   = be;
          if (lat[k] == 1) begin
            model_commit(k);
          end else begin
            m_inf[k] = 1'b1;
            m_rem[k] = lat[k] - 1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      n_checks++;
      if (saida_w[k] !== m_saida[k] || pronto_w[k] !== m_pronto[k] ||
          erro_w[k] !== m_erro[k] || ocup_w[k] !== m_inf[k]) begin
        n_err++;
        $display("FAIL model_cmp inst%0d lat%0d t=%0t: got saida=%h pronto=%b erro=%b ocup=%b, expected saida=%h pronto=%b erro=%b ocup=%b",
                 k, lat[k], $time, saida_w[k], pronto_w[k], erro_w[k], ocup_w[k],
                 m_saida[k], m_pronto[k], m_erro[k], m_inf[k]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input bit e, input bit l, input logic [31:0] a,
                       input logic [31:0] v, input logic [3:0] b);
    esc = e; ler = l; addr = a; val = v; be = b;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    repeat (n) tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r < 12)       return 32'($urandom_range(0, 31));
    else if (r == 12) return 32'd2047;
    else if (r == 13) return 32'd2048;
    else if (r == 14) return $urandom;
    else              return 32'($urandom_range(2040, 2047));
  endfunction

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < D; i++) m_mem[k][i] = 32'(i);
      m_inf[k] = 1'b0; m_rem[k] = 0; m_pronto[k] = 1'b0; m_erro[k] = 1'b0; m_saida[k] = '0;
      m_wr[k] = 1'b0; m_addr[k] = '0; m_val[k] = '0; m_be[k] = '0;
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk("reset_outputs", {saida_w[k][27:0], pronto_w[k], ocup_w[k], erro_w[k], 1'b0}, 32'd0);
      chk("reset_saida_hi", {28'd0, saida_w[k][31:28]}, 32'd0);
    end

    // Single read, LATENCIA=1
    drive(1'b0, 1'b1, 32'd5, 32'd0, 4'hF);
    tick();
    chk("l1_read5_saida", saida_w[0], 32'd5);
    chk("l1_read5_pronto", 32'(pronto_w[0]), 32'd1);
    chk("l1_read5_ocup", 32'(ocup_w[0]), 32'd0);
    chk("l3_busy_after_accept", 32'(ocup_w[1]), 32'd1);
    chk("model_pin_read5", m_saida[0], 32'd5);
    idle(1);
    chk("l1_saida_hold", saida_w[0], 32'd5);
    chk("l1_pronto_drop", 32'(pronto_w[0]), 32'd0);
    idle(4);

    // LATENCIA=3 write then read, with a read presented mid-wait
    drive(1'b1, 1'b0, 32'd10, 32'hDEADBEEF, 4'hF);
    tick();
    chk("l3_wr_ocup_c1", 32'(ocup_w[1]), 32'd1);
    chk("l3_wr_pronto_c1", 32'(pronto_w[1]), 32'd0);
    drive(1'b0, 1'b1, 32'd10, 32'd0, 4'hF);
    tick();
    chk("l3_wr_ocup_c2", 32'(ocup_w[1]), 32'd1);
    chk("l3_wr_pronto_c2", 32'(pronto_w[1]), 32'd0);
    chk("l1_raw_saida", saida_w[0], 32'hDEADBEEF);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    tick();
    chk("l3_wr_pronto_c3", 32'(pronto_w[1]), 32'd1);
    chk("l3_wr_ocup_c3", 32'(ocup_w[1]), 32'd0);
    chk("l3_wr_saida_unchanged", saida_w[1], 32'd5);
    tick();
    chk("l3_midwait_read_ignored", {30'd0, pronto_w[1], ocup_w[1]}, 32'd0);
    idle(4);
    drive(1'b0, 1'b1, 32'd10, 32'd0, 4'hF);
    tick();
    chk("l3_rd_ocup", 32'(ocup_w[1]), 32'd1);
    idle(2);
    chk("l3_rd_pronto", 32'(pronto_w[1]), 32'd1);
    chk("l3_rd_saida", saida_w[1], 32'hDEADBEEF);
    idle(4);

    // Back-to-back reads, LATENCIA=1
    for (int a = 2; a <= 4; a++) begin
      drive(1'b0, 1'b1, 32'(a), 32'd0, 4'hF);
      tick();
      chk("l1_b2b_pronto", 32'(pronto_w[0]), 32'd1);
      chk("l1_b2b_saida", saida_w[0], 32'(a));
    end
    idle(1);
    chk("l1_b2b_end", 32'(pronto_w[0]), 32'd0);
    idle(4);

    // Out of range, then the last valid word
    drive(1'b0, 1'b1, 32'd2048, 32'd0, 4'hF);
    tick();
    chk("oor_pronto", 32'(pronto_w[0]), 32'd1);
    chk("oor_erro", 32'(erro_w[0]), 32'd1);
    chk("oor_saida", saida_w[0], 32'd0);
    drive(1'b0, 1'b1, 32'd2047, 32'd0, 4'hF);
    tick();
    chk("last_saida", saida_w[0], 32'd2047);
    chk("last_erro", 32'(erro_w[0]), 32'd0);
    idle(5);

    // Both request lines high: write wins
    drive(1'b1, 1'b1, 32'd7, 32'h55, 4'hF);
    tick();
    chk("both_pronto", 32'(pronto_w[0]), 32'd1);
    chk("both_saida_unchanged", saida_w[0], 32'd2047);
    drive(1'b0, 1'b1, 32'd7, 32'd0, 4'hF);
    tick();
    chk("both_readback", saida_w[0], 32'h55);
    idle(5);

    // Partial-lane write to addr 20 (holds 0x14)
    drive(1'b1, 1'b0, 32'd20, 32'hAABBCCDD, 4'b0101);
    tick();
    drive(1'b0, 1'b1, 32'd20, 32'd0, 4'hF);
    tick();
`ifdef MEM_BYTE_WRITE_EN
    chk("byte_lane_readback", saida_w[0], 32'h00BB00DD);
`else
    chk("full_word_readback", saida_w[0], 32'hAABBCCDD);
`endif
    idle(5);

    // Reset two cycles into a LATENCIA=4 write
    drive(1'b1, 1'b0, 32'd30, 32'h1234, 4'hF);
    tick();
    idle(1);
    reset = 1'b1;
    tick();
    chk("rst_l4_saida", saida_w[2], 32'd0);
    chk("rst_l4_flags", {29'd0, pronto_w[2], ocup_w[2], erro_w[2]}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_l4_no_pronto", 32'(pronto_w[2]), 32'd0);
    end
    drive(1'b0, 1'b1, 32'd30, 32'd0, 4'hF);
    tick();
    chk("l1_committed_before_rst", saida_w[0], 32'h1234);
    idle(3);
    chk("rst_l4_read_pronto", 32'(pronto_w[2]), 32'd1);
    chk("rst_l4_read_saida", saida_w[2], 32'd30);
    chk("model_pin_rst", m_saida[2], 32'd30);
    idle(4);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), rand_addr(),
            $urandom, 4'($urandom_range(0, 15)));
      tick();
    end
    reset = 1'b0;
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/memoria_dados_param.md
Name: memoria_dados_param

Overview:
- Parametrised synchronous data memory for the pipeline's MEM stage; successor to the combinational word memory.
- Registered read/write with a configurable-latency request/ready handshake, out-of-range detection, and optional byte-lane writes.
- Word-addressed. The array is preloaded at elaboration so that word i holds i.

Parameters:
- LARGURA, 32: data width in bits; must be a multiple of 8.
- PROFUNDIDADE, 2048: number of words.
- LATENCIA, 1: cycles from request acceptance to memPronto; legal range 1..8.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- memEndereco  in  32  word index; only values below PROFUNDIDADE are valid.
- memValor  in  LARGURA  write data.
- memByteEn  in  LARGURA/8  byte-lane write enables; used only with MEM_BYTE_WRITE_EN.
- escreverMemoria  in  1  write request.
- lerMemoria  in  1  read request.
- saida  out  LARGURA  registered read data.
- memPronto  out  1  one-cycle completion pulse.
- memOcupado  out  1  high while a request is in flight and no new request can be accepted.
- memErro  out  1  qualifies memPronto; high when the completed access was out of range.

Behaviour:
- Reset (reset=1 at an edge):
  - State goes to OCIOSO; saida=0, memPronto=0, memOcupado=0, memErro=0; the wait counter clears.
  - An in-flight request is discarded; an uncommitted write never reaches the array.
  - Array contents are NOT cleared by reset.
- States: OCIOSO, ESPERA, RESPOSTA.
- Acceptance:
  - A request is accepted at an edge where the state is OCIOSO or RESPOSTA and (escreverMemoria | lerMemoria)=1.
  - If both request lines are high, the write wins and no read occurs.
  - On acceptance, address, data, byte enables and operation are latched.
- Transitions:
  - LATENCIA=1: accept goes straight to RESPOSTA.
  - LATENCIA>1: accept goes to ESPERA, with the counter loaded to LATENCIA-2.
  - In ESPERA the counter decrements each cycle; when it reaches 0 the next state is RESPOSTA.
  - In RESPOSTA, accepting a new request gives back-to-back operation; otherwise the next state is OCIOSO.
- Commit and memPronto timing:
  - The array write or read happens on the edge entering RESPOSTA.
  - memPronto=1 and saida are valid throughout the RESPOSTA cycle. For a request accepted at edge N, this is the cycle after edge N+LATENCIA-1.
  - With LATENCIA=1 the throughput is one access per cycle.
- saida rules:
  - A read loads the word into saida.
  - A write leaves saida unchanged.
  - saida holds its value between accesses.
- memOcupado: 1 in ESPERA, 0 in OCIOSO and RESPOSTA. Requests presented while memOcupado=1 are ignored (not queued); the requester must re-present after memPronto.
- Out of range (latched memEndereco >= PROFUNDIDADE):
  - No array write takes place.
  - saida is forced to 0 for a read and unchanged for a write.
  - memErro=1 together with memPronto; the same latency applies.
- Read-after-write to the same address in consecutive requests returns the new data, because commits are strictly ordered.
- Only the low clog2(PROFUNDIDADE) address bits index the array, after the range check.

Optional Feature:
- Macro: MEM_BYTE_WRITE_EN.
- Defined: on a write, byte lane k of the array word is updated only where memByteEn[k]=1. A write with memByteEn all-zero completes normally (memPronto pulses) but leaves the word unchanged.
- Undefined: memByteEn is ignored and every write updates the full word.

Decomposition:
- Package memoria_pkg:
  - State enum {OCIOSO, ESPERA, RESPOSTA}.
  - Operation type {OP_LER, OP_ESCREVER}.
  - Default width and depth constants.
  - A counter-width function of LATENCIA.
- Sub-module memoria_array:
  - Storage with synchronous single-port access: write enable, per-lane enables, registered read.
  - Elaboration-time preload of i at word i.
  - The top level holds the FSM, latching, range check and saida/memErro muxing.

Test Plan:
- LATENCIA=1. Read addr 5 at cycle 0, then hold the request lines low → memPronto=1 in cycle 1, saida=5, memErro=0, memOcupado=0 throughout.
- LATENCIA=3:
  - Write 0xDEADBEEF to addr 10, then read addr 10 → each memPronto comes 3 cycles after acceptance; memOcupado=1 in the 2 cycles between.
  - The read returns 0xDEADBEEF.
  - A read presented mid-wait is ignored.
- LATENCIA=1. Present read addr 2, 3 and 4 on consecutive cycles → memPronto stays high for 3 cycles; saida = 2, 3, 4 in successive cycles.
- Read addr 2048 (PROFUNDIDADE=2048) → memPronto=1 with memErro=1 and saida=0. A subsequent read of addr 2047 returns 2047, with memErro=0.
- Both request lines high, addr 7, memValor=0x55 → write only; saida unchanged. A subsequent read of addr 7 gives 0x55.
- With MEM_BYTE_WRITE_EN, write 0xAABBCCDD to addr 20 with memByteEn=4'b0101, where addr 20 holds 0x00000014 → a read gives 0x00BB00DD.
- LATENCIA=4. Assert reset 2 cycles into a write to addr 30 → memPronto never pulses, all outputs read 0, and a later read of addr 30 returns 30.
